// File: rtl/add3_result_stage.sv
// -----------------------------------------------------------------------------
// add3_result_stage
//   Capture stage for the 3-bit ripple adder result {cout3,s2,s1,s0}.
//   Presents the captured result on a valid/ready stream through a 2-entry
//   skid buffer (head + skid), so in_ready is a register output and the
//   consumer's back-pressure never reaches the source combinationally.
//   Also keeps a saturating count of accepted beats whose carry was set.
//
//   Build option: define ADD3_SATURATE_EN to clamp the stored sum to 3'b111
//   whenever cout3=1. Without it the stored sum is the raw {s2,s1,s0}
//   (modulo-8 wrap). out_carry and ovf_count behave the same in both builds.
// -----------------------------------------------------------------------------
module add3_result_stage #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             s0,
    input  logic             s1,
    input  logic             s2,
    input  logic             cout3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_sum,
    output logic             out_carry,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] ovf_count
);

    // Buffer occupancy: nothing held, head only, head and skid both full.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t     state;
    logic       push;
    logic       pop;
    logic [2:0] in_sum;
    logic [2:0] skid_sum;
    logic       skid_carry;

    // Stream handshakes; in_ready and out_valid are both registers.
    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Sum value as it is stored in either entry.
`ifdef ADD3_SATURATE_EN
    assign in_sum = cout3 ? 3'b111 : {s2, s1, s0};
`else
    assign in_sum = {s2, s1, s0};
`endif

    // Occupancy FSM; the head entry is the output register itself, and
    // in_ready/out_valid are loaded with the value the next state implies.
    always_ff @(posedge clk) begin
        // NOTE: every register here is assigned with <= so all of them update
        // from the pre-edge values; a blocking = would let later statements
        // see already-updated state and change the behaviour with ordering.
        if (!rst_n) begin
            state     <= EMPTY;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= 3'b000;
            out_carry <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    in_ready <= 1'b1;
                    if (push) begin
                        state     <= ONE;
                        out_valid <= 1'b1;
                        out_sum   <= in_sum;
                        out_carry <= cout3;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        out_sum   <= in_sum;
                        out_carry <= cout3;
                    end else if (push) begin
                        // Head is stalled; the new beat goes to the skid entry.
                        state    <= TWO;
                        in_ready <= 1'b0;
                    end else if (pop) begin
                        // Head data is left in place so out_sum/out_carry
                        // keep their last value while empty.
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                TWO: begin
                    // in_ready is 0 here, so only a pop can happen.
                    if (pop) begin
                        state     <= ONE;
                        in_ready  <= 1'b1;
                        out_sum   <= skid_sum;
                        out_carry <= skid_carry;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Skid entry capture: only when a push arrives while the head is stalled.
    always_ff @(posedge clk) begin
        // NOTE: the skid entry has no reset; it is only ever read in TWO, which
        // is reachable solely after it has been written, so its power-up
        // contents are never observed.
        if (state == ONE && push && !pop) begin
            skid_sum   <= in_sum;
            skid_carry <= cout3;
        end
    end

    // Saturating count of accepted overflowing beats; clear beats increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_count <= '0;
        end else if (ovf_clr) begin
            ovf_count <= '0;
        end else if (push && cout3 && (ovf_count != {CNT_W{1'b1}})) begin
            ovf_count <= ovf_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_add3_result_stage.sv
// -----------------------------------------------------------------------------
// tb_add3_result_stage
//   Self-checking bench for add3_result_stage (built with CNT_W=2 so counter
//   saturation is reachable). A queue-based model of the stream tracks the
//   expected outputs; a compare process checks them every cycle, and the
//   directed sequences pin selected values with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_add3_result_stage;

    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             s0, s1, s2, cout3;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_sum;
    logic             out_carry;
    logic             ovf_clr;
    logic [CNT_W-1:0] ovf_count;

    int n_checks = 0;
    int n_errors = 0;
    int dut_pops = 0;
    bit chk_en   = 1'b0;

    add3_result_stage #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s0        (s0),
        .s1        (s1),
        .s2        (s2),
        .cout3     (cout3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .ovf_clr   (ovf_clr),
        .ovf_count (ovf_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Beats are stored as {carry, stored_sum}.
    logic [3:0] q[$];
    logic [3:0] m_last  = 4'h0;
    bit         m_ready = 1'b0;
    int         m_count = 0;

    function automatic logic [3:0] stored_beat(input logic c, input logic [2:0] s);
`ifdef ADD3_SATURATE_EN
        return {c, (c ? 3'd7 : s)};
`else
        return {c, s};
`endif
    endfunction

    always @(posedge clk) begin
        bit m_push, m_pop;
        if (!rst_n) begin
            q.delete();
            m_last  = 4'h0;
            m_ready = 1'b0;
            m_count = 0;
        end else begin
            m_push = in_valid && m_ready;
            m_pop  = (q.size() > 0) && out_ready;
            if (m_pop) begin
                m_last = q[0];
                void'(q.pop_front());
            end
            if (m_push) q.push_back(stored_beat(cout3, {s2, s1, s0}));
            if (ovf_clr) m_count = 0;
            else if (m_push && cout3 && m_count < CMAX) m_count = m_count + 1;
            m_ready = (q.size() < 2);
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [3:0] head;
        if (chk_en) begin
            head = (q.size() > 0) ? q[0] : m_last;
            check("in_ready",  32'(in_ready),  32'(m_ready));
            check("out_valid", 32'(out_valid), 32'(q.size() > 0));
            check("out_sum",   32'(out_sum),   32'(head[2:0]));
            check("out_carry", 32'(out_carry), 32'(head[3]));
            check("ovf_count", 32'(ovf_count), 32'(m_count));
            if (out_valid && out_ready) dut_pops++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input logic c, input logic [2:0] s, input bit ordy);
        in_valid  = v;
        cout3     = c;
        {s2, s1, s0} = s;
        out_ready = ordy;
    endtask

    initial begin
        int start_pops;
        bit drained;
        rst_n = 1'b0; ovf_clr = 1'b0;
        drive(1'b1, 1'b0, 3'b000, 1'b0);

        // 1. Reset held 3 cycles with in_valid=1.
        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ovf_count", 32'(ovf_count), 32'd0);
        check("rst_out_sum",   32'(out_sum),   32'd0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 3'b000, 1'b0);
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'd1);

        // 2. Single beat 0_101.
        drive(1'b1, 1'b0, 3'b101, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 1'b1);
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_sum",   32'(out_sum),   32'd5);
        check("single_carry", 32'(out_carry), 32'd0);
        @(negedge clk);
        check("single_drained", 32'(out_valid), 32'd0);
        check("single_hold_sum", 32'(out_sum), 32'd5);

        // 3. Back-pressure: two beats with out_ready=0.
        drive(1'b1, 1'b0, 3'b001, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 3'b010, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 1'b0);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_sum_a",    32'(out_sum),  32'd1);
        @(negedge clk);
        check("bp_sum_stable", 32'(out_sum), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_sum_b",     32'(out_sum),  32'd2);
        check("bp_in_ready1", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("bp_empty", 32'(out_valid), 32'd0);

        // 4. Overflow beat 1_011.
        drive(1'b1, 1'b1, 3'b011, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 1'b1);
        check("ovf_count1", 32'(ovf_count), 32'd1);
        check("ovf_carry",  32'(out_carry), 32'd1);
`ifdef ADD3_SATURATE_EN
        check("ovf_sum", 32'(out_sum), 32'd7);
`else
        check("ovf_sum", 32'(out_sum), 32'd3);
`endif
        @(negedge clk);

        // 5. Counter saturation and clear priority.
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("clr_only", 32'(ovf_count), 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 3'(i), 1'b1);
            @(negedge clk);
            check("sat_count", 32'(ovf_count), 32'((i + 1 > 3) ? 3 : i + 1));
        end
        ovf_clr = 1'b1;
        drive(1'b1, 1'b1, 3'b110, 1'b1);
        @(negedge clk);
        ovf_clr = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 1'b1);
        check("clr_wins", 32'(ovf_count), 32'd0);
        @(negedge clk);

        // 6. Streaming 16 beats, then reset with 2 beats buffered.
        start_pops = dut_pops;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b1);
            @(negedge clk);
            check("stream_in_ready", 32'(in_ready), 32'd1);
        end
        drive(1'b0, 1'b0, 3'b000, 1'b1);
        drained = 1'b0;
        for (int i = 0; i < 10 && !drained; i++) begin
            @(negedge clk);
            drained = !out_valid;
        end
        check("stream_drained", 32'(drained), 32'd1);
        check("stream_pops", 32'(dut_pops - start_pops), 32'd16);

        drive(1'b1, 1'b0, 3'b100, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 3'b111, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 1'b0);
        check("two_buffered", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_ready", 32'(in_ready),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized traffic with occasional clear and reset.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 2) != 0));
            ovf_clr = ($urandom_range(0, 40) == 0);
            rst_n   = ($urandom_range(0, 250) != 0);
            @(negedge clk);
        end
        rst_n = 1'b1; ovf_clr = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 1'b1);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
